// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile
//
// General-purpose register file for the five-stage MIPS core.
// 32 x 32-bit registers, two combinational read ports for the ID stage and
// one synchronous write port driven by the WB stage. Register $0 reads as
// zero and has no storage behind it.
//
// Ports:
//   clk     in   core clock, all state updates on the rising edge
//   rst     in   synchronous active-high reset, clears registers 1..31
//   we      in   write enable from WB
//   waddr   in   write register address
//   wdata   in   write data
//   re1     in   port-1 read enable from ID
//   raddr1  in   port-1 read address
//   rdata1  out  port-1 read data (combinational)
//   re2     in   port-2 read enable from ID
//   raddr2  in   port-2 read address
//   rdata2  out  port-2 read data (combinational)
//
// Configuration macro:
//   REGFILE_WR_BYPASS_EN  when defined, a read of the address WB is writing
//                         in the same cycle returns wdata instead of the
//                         stored value. When undefined, such a read returns
//                         the old stored value.
// ---------------------------------------------------------------------------
module regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    // Storage exists only for registers 1..NUM_REGS-1; $0 is never stored.
    logic [DATA_W-1:0] r_regs [1:NUM_REGS-1];

    // Write qualifier: address zero is silently dropped.
    logic w_wrValid;
    assign w_wrValid = we && (waddr != '0);

    // Reset wins over a write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wrValid) begin
            r_regs[waddr] <= wdata;
        end
    end

    // Bypass hit flags. With the bypass disabled they are tied low so the
    // read path below is identical in both builds apart from this point.
    logic w_byp1;
    logic w_byp2;
`ifdef REGFILE_WR_BYPASS_EN
    assign w_byp1 = we && (waddr == raddr1);
    assign w_byp2 = we && (waddr == raddr2);
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    // Port 1 read. The checks for reset, disabled port and $0 come first,
    // so storage is only indexed with a non-zero address.
    always_comb begin
        rdata1 = '0;
        if (rst) begin
            rdata1 = '0;
        end else if (!re1) begin
            rdata1 = '0;
        end else if (raddr1 == '0) begin
            rdata1 = '0;
        end else if (w_byp1) begin
            rdata1 = wdata;
        end else begin
            rdata1 = r_regs[raddr1];
        end
    end

    // Port 2 read, same priority order as port 1.
    always_comb begin
        rdata2 = '0;
        if (rst) begin
            rdata2 = '0;
        end else if (!re2) begin
            rdata2 = '0;
        end else if (raddr2 == '0) begin
            rdata2 = '0;
        end else if (w_byp2) begin
            rdata2 = wdata;
        end else begin
            rdata2 = r_regs[raddr2];
        end
    end

endmodule
